// File: rtl/minisys_md_pkg.sv
// Shared definitions for the Minisys multiply/divide unit: op encodings,
// FSM states and the iteration count.
package minisys_md_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = $clog2(MD_ITERS);
endpackage

// File: rtl/md_addsub.sv
// W-bit add/subtract with carry-out. On subtract, carry-out = 1 means no borrow.
module md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o,
  output logic         cout_o
);
  logic [W:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{W{1'b0}}, sub_i};
  assign {cout_o, y_o} = sum;
endmodule

// File: rtl/minisys_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 magnitude iterations, one sign-fix
// cycle, then a one-cycle HI/LO write strobe.
module minisys_muldiv
  import minisys_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] md_a,
  input  logic [XLEN-1:0] md_b,
  input  logic            md_flush,
  output logic            md_busy,
  output logic            md_cs,
  output logic [XLEN-1:0] md_hi,
  output logic [XLEN-1:0] md_lo
);
  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITERS - 1);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  // Working pair: product {hi,lo} for multiply; {remainder, dividend/quotient} for divide
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]     opnd_q, opnd_d, aorig_q, aorig_d;
  logic [XLEN-1:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic                div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, divz_q, divz_d;
  logic                cs_q, cs_d;

  md_op_e          op_in;
  logic            is_div, is_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op_in  = md_op_e'(md_op);
  assign is_div = (op_in == MD_DIV) || (op_in == MD_DIVU);
  assign is_sgn = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign a_neg  = is_sgn & md_a[XLEN-1];
  assign b_neg  = is_sgn & md_b[XLEN-1];
  assign a_mag  = a_neg ? -md_a : md_a;
  assign b_mag  = b_neg ? -md_b : md_b;

  // Divide: trial-subtract divisor from the shifted remainder; multiply: accumulate multiplicand
  logic [XLEN:0] add_a, add_b, add_y, mul_sh;
  logic          add_cout;

  assign add_a = div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
  assign add_b = {1'b0, opnd_q};

  md_addsub #(.W(XLEN + 1)) u_addsub (
    .a_i   (add_a),
    .b_i   (add_b),
    .sub_i (div_q),
    .y_o   (add_y),
    .cout_o(add_cout)
  );

  assign mul_sh = lo_q[0] ? add_y : {1'b0, hi_q};

  logic [2*XLEN-1:0] prod_fix;
  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    aorig_d  = aorig_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    cs_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (md_start) begin
        state_d = ST_CALC;
        cnt_d   = '0;
        div_d   = is_div;
        neg_d   = a_neg ^ b_neg;
        rneg_d  = a_neg;
        divz_d  = is_div && (md_b == '0);
        aorig_d = md_a;
        opnd_d  = is_div ? b_mag : a_mag;
        hi_d    = '0;
        lo_d    = is_div ? a_mag : b_mag;
      end
      ST_CALC: begin
        if (div_q) begin
          hi_d = add_cout ? add_y[XLEN-1:0] : add_a[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], add_cout};
        end else begin
          hi_d = mul_sh[XLEN:1];
          lo_d = {mul_sh[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        cs_d    = 1'b1;
        if (divz_q) begin
          res_hi_d = aorig_q;
          res_lo_d = '1;
        end else if (div_q) begin
          res_hi_d = rneg_q ? -hi_q : hi_q;
          res_lo_d = neg_q ? -lo_q : lo_q;
        end else begin
          {res_hi_d, res_lo_d} = prod_fix;
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
    if (md_flush) begin
      state_d  = ST_IDLE;
      cs_d     = 1'b0;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      aorig_q  <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      cs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      aorig_q  <= aorig_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      divz_q   <= divz_d;
      cs_q     <= cs_d;
    end
  end

  assign md_busy = (state_q != ST_IDLE);
  assign md_cs   = cs_q;
  assign md_hi   = res_hi_q;
  assign md_lo   = res_lo_q;
endmodule

// File: tb/tb_minisys_muldiv.sv
// Bench for minisys_muldiv: arithmetic reference model checked every cycle,
// plus directed vectors with literal expected HI/LO and latency.
module tb_minisys_muldiv;
  import minisys_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst, md_start, md_flush, md_busy, md_cs;
  logic [1:0]  md_op;
  logic [31:0] md_a, md_b, md_hi, md_lo;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  minisys_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .md_flush(md_flush),
    .md_busy(md_busy), .md_cs(md_cs), .md_hi(md_hi), .md_lo(md_lo)
  );

  // Returns {HI, LO} straight from integer arithmetic
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    longint sa, sb, q, r;
    logic [63:0] qq, rr;
    case (op)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          sa = $signed(a);
          sb = $signed(b);
          q = sa / sb;
          r = sa % sb;
          qq = q;
          rr = r;
          return {rr[31:0], qq[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: cycles remaining until idle; result lands when one cycle remains
  int          m_left = 0;
  logic        m_cs = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_cs   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_cs <= 1'b0;
      if (m_left > 0) begin
        if (md_flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 2) begin
            m_cs <= 1'b1;
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
          end
        end
      end else if (md_start && !md_flush) begin
        m_left <= 34;
        m_pend <= ref_md(md_op, md_a, md_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_busy", {31'b0, md_busy}, {31'b0, (m_left > 0)});
      chk("cmp_cs", {31'b0, md_cs}, {31'b0, m_cs});
      chk("cmp_hi", md_hi, m_hi);
      chk("cmp_lo", md_lo, m_lo);
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge of cycle 35
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm, input bit junk);
    int n;
    md_op = op; md_a = a; md_b = b; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    n = 1;
    while (md_cs !== 1'b1 && n < 40) begin
      if (junk && n == 5) begin
        md_start = 1'b1;
        md_a = ~a;
      end else md_start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, 34);
    chk({nm, "_hi"}, md_hi, eh);
    chk({nm, "_lo"}, md_lo, el);
    if (junk) md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    chk({nm, "_idle35"}, {31'b0, md_busy}, 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; md_start = 1'b0; md_flush = 1'b0; md_op = '0; md_a = '0; md_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, md_busy}, 32'd0);
    chk("rst_cs", {31'b0, md_cs}, 32'd0);
    chk("rst_hi", md_hi, 32'd0);
    chk("rst_lo", md_lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b1);
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 1'b0);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min", 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7", 1'b1);
    run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_m2", 1'b0);
    run_op(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7", 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf", 1'b0);
    run_op(MD_DIVU,  32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, "divu_z", 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_z_neg", 1'b0);
    run_op(MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, "divu_by1", 1'b0);
    run_op(MD_DIVU,  32'h0000_00BA, 32'h10,        32'hA,         32'hB,         "divu_ab", 1'b0);

    // Flush at cycle 10 of a MULT: no strobe, HI/LO keep 0xA/0xB
    md_op = MD_MULT; md_a = 32'd5; md_b = 32'd6; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    repeat (9) @(negedge clk);
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    chk("flush_busy", {31'b0, md_busy}, 32'd0);
    chk("flush_hi", md_hi, 32'hA);
    chk("flush_lo", md_lo, 32'hB);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | md_cs;
    end
    chk("flush_nocs", {31'b0, seen}, 32'd0);

    // Flush beats a simultaneous start in IDLE
    md_start = 1'b1; md_flush = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_flush = 1'b0;
    chk("flush_start_busy", {31'b0, md_busy}, 32'd0);

    // Reset at cycle 20 of a DIV
    md_op = MD_DIV; md_a = 32'd1000; md_b = 32'd3; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'b0, md_busy}, 32'd0);
    chk("mid_rst_cs", {31'b0, md_cs}, 32'd0);
    chk("mid_rst_hi", md_hi, 32'd0);
    chk("mid_rst_lo", md_lo, 32'd0);
    run_op(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "multu_3_5", 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/minisys_muldiv.md
# minisys_muldiv

Iterative multiply/divide unit for the Minisys pipeline. It accepts MULT/MULTU/DIV/DIVU from the execute stage and computes the result over 34 cycles while signalling busy to the hazard unit. On completion it emits a one-cycle HI/LO write strobe with data. These outputs are carried through the pipeline as the md write-back controls (`mdcs`, `mdhidata`, `mdlodata`) consumed by write-back.

## Interface
- `XLEN`, 32, operand width; only 32 is supported and verified.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `md_start` in 1: request a new operation; sampled only in IDLE.
- `md_op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `md_a` in XLEN: rs operand (multiplicand / dividend).
- `md_b` in XLEN: rt operand (multiplier / divisor).
- `md_flush` in 1: abort the in-flight operation (exception / pipeline flush).
- `md_busy` out 1: high whenever state ≠ IDLE; stalls issue of mult/div, mfhi, mflo, mthi, mtlo.
- `md_cs` out 1: one-cycle HI/LO write strobe.
- `md_hi` out XLEN: HI result; product[63:32] or remainder.
- `md_lo` out XLEN: LO result; product[31:0] or quotient.

## Operation
- States: IDLE → CALC (32 cycles, 5-bit counter 0..31) → FIX (1) → DONE (1) → IDLE.
- **Start.** In IDLE with `md_start`=1, latch the op, signedness, both operand magnitudes, and the result sign(s). Clear the counter and go to CALC.
- **Multiply.** Shift-add on unsigned magnitudes into a 64-bit accumulator, one multiplier bit per CALC cycle.
- **Divide.** Restoring division on magnitudes with a 33-bit partial remainder, one quotient bit per CALC cycle.
- **Signed fix.** FIX negates as needed:
  - 64-bit product when the operand signs differ.
  - Quotient when the operand signs differ.
  - Remainder when the dividend is negative.
  - Unsigned ops pass through FIX unchanged.
- **Divide by zero** (`md_b`=0, either signedness): HI = original `md_a`, LO = 0xFFFF_FFFF. Latency is unchanged and no trap is raised.
- **Overflow.** DIV 0x8000_0000 / 0xFFFF_FFFF gives LO = 0x8000_0000, HI = 0. This must fall out of the magnitude algorithm and must not be special-cased incorrectly.
- **DONE.** `md_cs`=1 for exactly that cycle. `md_hi`/`md_lo` update on entry to DONE and then hold until the next DONE.
- **Flush.** `md_flush` in any state sends the unit to IDLE at the next edge. No `md_cs` is produced and `md_hi`/`md_lo` are unchanged. Flush overrides a simultaneous `md_start`.
- **Start while busy.** `md_start` with state ≠ IDLE (including DONE) is ignored. Upstream must hold the instruction while `md_busy`=1.
- **Reset.** Takes priority over everything. State = IDLE, counter = 0, `md_busy`=0, `md_cs`=0, `md_hi`=0, `md_lo`=0.

## Timing
- Start sampled at edge 0:
  - Cycles 1–32: CALC.
  - Cycle 33: FIX.
  - Cycle 34: DONE, with `md_cs`=1 and results valid.
  - Cycle 35: IDLE.
- `md_busy` is high in cycles 1–34 and low in cycle 0 and cycle 35.
- The earliest back-to-back start is sampled at the edge opening cycle 35. Issue interval is 35 cycles.
- `md_cs`, `md_hi` and `md_lo` are registered; `md_busy` is decoded from registered state only.
- Reset or flush mid-CALC: `md_busy` drops the cycle after the edge and no strobe follows.

## Structure
- Shared package `minisys_md_pkg`:
  - `md_op` encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - State enum.
  - Iteration count constant MD_ITERS = 32.
- Sub-module `md_addsub`: a 33-bit add/subtract with carry-out, shared by the multiply accumulate and the divide trial subtraction.
- The FSM, counter and sign-fix negation stay in `minisys_muldiv`.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → cycle 34: HI = 0xFFFF_FFFE, LO = 0x0000_0001, `md_cs` high 1 cycle, busy cycles 1–34.
- MULT 0xFFFF_FFFD (−3) × 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB (−21).
- DIV −7 / 2 → LO = 0xFFFF_FFFD (−3), HI = 0xFFFF_FFFF (−1); DIVU 100 / 7 → LO = 14, HI = 2.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0; DIVU 0x1234 / 0 → HI = 0x1234, LO = 0xFFFF_FFFF.
- Flush at cycle 10 of a MULT with HI/LO previously 0xA/0xB → busy low from cycle 11, no `md_cs`, HI/LO remain 0xA/0xB. `md_start` during cycles 1–34 is ignored.
- `rst` asserted at cycle 20 of a DIV → next cycle all outputs 0, state IDLE. A new MULTU 3 × 5 started immediately after yields LO = 15, HI = 0 at 34 cycles.
